// File: rtl/uart_pkg.sv
// Shared UART types and helpers: parity mode, receiver FSM states, parity compute.
// Used by the receiver and intended for reuse on the transmit side.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Payload is zero-extended to the widest frame; the padding does not change the XOR.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] payload,
                                       input parity_e mode);
    logic x;
    x = ^payload;
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, restartable so the
// sampling phase can be aligned to an external event such as a start edge.
module uart_baud_tick #(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int BAUD             = 115200,
  parameter int OVERSAMPLE       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int DIV   = CLK_FREQUENCY_HZ / (BAUD * OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: clock too slow for BAUD*OVERSAMPLE (DIV < 1)");
  end

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == CNT_MAX)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A restart swallows any tick due in the same cycle so the new phase starts clean.
  assign o_tick = (r_cnt == CNT_MAX) && !i_restart;

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver: oversampled majority-vote sampling, optional parity,
// 1 or 2 stop bits, valid/ready word output with parity/frame/overrun flags.
module uart_rx_framed #(
  parameter int CLK_FREQUENCY_HZ = 100000000,
  parameter int BAUD             = 115200,
  parameter int OVERSAMPLE       = 16,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  import uart_pkg::*;

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
    $error("uart_rx_framed: OVERSAMPLE must be even and >= 4");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_bad_data
    $error("uart_rx_framed: DATA_BITS must be 5..9");
  end
  if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_par
    $error("uart_rx_framed: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
    $error("uart_rx_framed: STOP_BITS must be 1 or 2");
  end

  localparam parity_e PAR_MODE = parity_e'(PARITY);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] SAMP_LO  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] SAMP_HI  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  logic                        r_sync1, r_rx_s, r_rx_prev;
  rx_state_e                   r_state, w_state_nxt;
  logic [OS_W-1:0]             r_os_cnt;
  logic [1:0]                  r_samp;
  logic [3:0]                  r_bit_cnt;
  logic [DATA_BITS-1:0]        r_shift;
  logic                        r_perr, r_ferr;
  logic [DATA_BITS-1:0]        r_data;
  logic                        r_valid, r_parity_err, r_frame_err, r_overrun;

  logic                        w_tick, w_restart, w_samp, w_dec, w_maj, w_par_exp;
  logic                        w_deliver, w_shift_en, w_par_en, w_stop_en;
  logic                        w_bit_inc, w_bit_clr;
  logic [MAX_DATA_BITS-1:0]    w_payload;

  uart_baud_tick #(
    .CLK_FREQUENCY_HZ (CLK_FREQUENCY_HZ),
    .BAUD             (BAUD),
    .OVERSAMPLE       (OVERSAMPLE)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= uart_rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // The start edge counts as tick 0 of the bit, so ticks OS/2-1..OS/2+1 straddle mid-bit.
  assign w_samp    = w_tick && (r_os_cnt >= SAMP_LO) && (r_os_cnt <= SAMP_HI);
  assign w_dec     = w_tick && (r_os_cnt == SAMP_HI);
  assign w_maj     = (r_samp[1] & r_samp[0]) | (r_samp[1] & r_rx_s) | (r_samp[0] & r_rx_s);
  assign w_payload = MAX_DATA_BITS'(r_shift);
  assign w_par_exp = parity_calc(w_payload, PAR_MODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_deliver   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_en   = 1'b0;
    w_bit_inc   = 1'b0;
    w_bit_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rx_prev && !r_rx_s) begin
          w_restart   = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_dec) begin
          if (w_maj) begin
            w_state_nxt = IDLE;
          end else begin
            w_bit_clr   = 1'b1;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_dec) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_clr   = 1'b1;
            w_state_nxt = (PAR_MODE != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (w_dec) begin
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_dec) begin
          w_stop_en = 1'b1;
          if (r_bit_cnt == STOP_LAST) begin
            w_deliver   = 1'b1;
            w_state_nxt = r_rx_s ? IDLE : BREAK;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      BREAK: begin
        if (r_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_os_cnt  <= '0;
      r_samp    <= 2'b11;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_restart) begin
        r_os_cnt <= OS_W'(1);
      end else if (w_tick) begin
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
      end
      if (w_samp) begin
        r_samp <= {r_samp[0], r_rx_s};
      end
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      end
      if (w_restart) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else begin
        if (w_par_en) begin
          r_perr <= w_maj ^ w_par_exp;
        end
        if (w_stop_en && !w_maj) begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  // A word completing while the previous one is still unaccepted is dropped, not queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_deliver) begin
      if (!r_valid || ready) begin
        r_data       <= r_shift;
        r_parity_err <= r_perr;
        r_frame_err  <= r_ferr | ~w_maj;
        r_valid      <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench: an 8N1 receiver and an 8E1 receiver on separate lines, shared clock/reset.
module tb_uart_rx_framed;

  localparam int CLK_HZ  = 160;
  localparam int BAUD_R  = 10;
  localparam int OS      = 4;
  localparam int BIT_CLK = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx0, rx1, ready0, ready1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

  uart_rx_framed #(
    .CLK_FREQUENCY_HZ (CLK_HZ), .BAUD (BAUD_R), .OVERSAMPLE (OS),
    .DATA_BITS (8), .PARITY (0), .STOP_BITS (1)
  ) u_dut (
    .clk (clk), .rst (rst), .uart_rx (rx0), .data (data0), .valid (valid0),
    .ready (ready0), .parity_err (perr0), .frame_err (ferr0), .overrun (ovr0),
    .busy (busy0)
  );

  uart_rx_framed #(
    .CLK_FREQUENCY_HZ (CLK_HZ), .BAUD (BAUD_R), .OVERSAMPLE (OS),
    .DATA_BITS (8), .PARITY (2), .STOP_BITS (1)
  ) u_dut_par (
    .clk (clk), .rst (rst), .uart_rx (rx1), .data (data1), .valid (valid1),
    .ready (ready1), .parity_err (perr1), .frame_err (ferr1), .overrun (ovr1),
    .busy (busy1)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   got0 = 0;
  int   got1 = 0;
  int   vcyc0 = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid0) vcyc0++;
    if (valid0 && ready0) begin
      if (q0.size() == 0) begin
        check_eq("unexpected_word0", 32'(data0), 32'hFFFF_FFFF);
      end else begin
        e0 = q0.pop_front();
        check_eq("data0", 32'(data0), 32'(e0.d));
        check_eq("parity_err0", 32'(perr0), 32'(e0.pe));
        check_eq("frame_err0", 32'(ferr0), 32'(e0.fe));
      end
      got0++;
    end
  end

  always @(negedge clk) begin
    if (valid1 && ready1) begin
      if (q1.size() == 0) begin
        check_eq("unexpected_word1", 32'(data1), 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        check_eq("data1", 32'(data1), 32'(e1.d));
        check_eq("parity_err1", 32'(perr1), 32'(e1.pe));
        check_eq("frame_err1", 32'(ferr1), 32'(e1.fe));
      end
      got1++;
    end
  end

  task automatic bit_out(input int ln, input logic v);
    if (ln == 0) rx0 = v;
    else         rx1 = v;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int ln, input logic [7:0] d, input bit use_par,
                            input logic pbit, input logic stop_lvl);
    bit_out(ln, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(ln, d[i]);
    if (use_par) bit_out(ln, pbit);
    bit_out(ln, stop_lvl);
    bit_out(ln, 1'b1);
  endtask

  task automatic wait_words(input int ln, input int n, input int budget);
    int k;
    k = 0;
    while ((((ln == 0) ? got0 : got1) < n) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq((ln == 0) ? "word_count0" : "word_count1",
             32'((ln == 0) ? got0 : got1), 32'(n));
  endtask

  task automatic par_case(input logic [7:0] d, input logic pbit, input int n);
    exp_t x;
    x.d  = d;
    x.pe = pbit ^ (^d);
    x.fe = 1'b0;
    q1.push_back(x);
    send_frame(1, d, 1'b1, pbit, 1'b1);
    wait_words(1, n, 64);
  endtask

  initial begin
    exp_t x;
    int   v_before;
    rst    = 1'b1;
    rx0    = 1'b1;
    rx1    = 1'b1;
    ready0 = 1'b1;
    ready1 = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(data0), 32'h0);
    check_eq("rst_valid", 32'(valid0), 32'h0);
    check_eq("rst_perr", 32'(perr0), 32'h0);
    check_eq("rst_ferr", 32'(ferr0), 32'h0);
    check_eq("rst_overrun", 32'(ovr0), 32'h0);
    check_eq("rst_busy", 32'(busy0), 32'h0);
    rst = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
    #1;

    // 8N1 frame 0xA5, valid must be a one-cycle pulse with ready high
    x = '{d: 8'hA5, pe: 1'b0, fe: 1'b0};
    q0.push_back(x);
    v_before = vcyc0;
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_words(0, 1, 64);
    check_eq("a5_valid_cycles", 32'(vcyc0 - v_before), 32'd1);
    check_eq("a5_overrun", 32'(ovr0), 32'h0);
    check_eq("a5_busy", 32'(busy0), 32'h0);

    // even parity receiver: correct parity, wrong parity, odd-popcount byte
    par_case(8'h03, 1'b0, 1);
    par_case(8'h03, 1'b1, 2);
    par_case(8'h07, 1'b1, 3);

    // short glitch is a false start
    rx0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("glitch_busy_high", 32'(busy0), 32'h1);
    repeat (2) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("glitch_busy_low", 32'(busy0), 32'h0);
    repeat (BIT_CLK) @(posedge clk);
    #1;
    check_eq("glitch_no_word", 32'(got0), 32'd1);

    // overrun: second word dropped while the first is held
    ready0 = 1'b0;
    x = '{d: 8'h11, pe: 1'b0, fe: 1'b0};
    q0.push_back(x);
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1);
    check_eq("ovr_valid", 32'(valid0), 32'h1);
    check_eq("ovr_data_held", 32'(data0), 32'h11);
    check_eq("ovr_flag", 32'(ovr0), 32'h1);
    ready0 = 1'b1;
    wait_words(0, 2, 8);
    repeat (2) @(posedge clk);
    #1;
    check_eq("ovr_valid_drop", 32'(valid0), 32'h0);
    check_eq("ovr_sticky", 32'(ovr0), 32'h1);

    // line held low: framing error, then break until the line recovers
    x = '{d: 8'h00, pe: 1'b0, fe: 1'b1};
    q0.push_back(x);
    rx0 = 1'b0;
    repeat (11 * BIT_CLK) @(posedge clk);
    #1;
    check_eq("brk_word", 32'(got0), 32'd3);
    check_eq("brk_busy", 32'(busy0), 32'h1);
    check_eq("brk_ferr_held", 32'(ferr0), 32'h1);
    repeat (19 * BIT_CLK) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    #1;
    check_eq("brk_busy_low", 32'(busy0), 32'h0);
    check_eq("brk_single_word", 32'(got0), 32'd3);

    // reset in the middle of the data bits of 0x5A
    bit_out(0, 1'b0);
    bit_out(0, 1'b0);
    bit_out(0, 1'b1);
    rx0 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_eq("mid_busy_before", 32'(busy0), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(valid0), 32'h0);
    check_eq("mid_rst_busy", 32'(busy0), 32'h0);
    check_eq("mid_rst_overrun", 32'(ovr0), 32'h0);
    rx0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (BIT_CLK) @(posedge clk);
    #1;
    x = '{d: 8'h3C, pe: 1'b0, fe: 1'b0};
    q0.push_back(x);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_words(0, 4, 64);
    check_eq("q0_drained", 32'(q0.size()), 32'd0);
    check_eq("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds the following over that receiver:
- configurable data width, parity and stop bits;
- oversampled majority-vote bit sampling;
- a valid/ready output handshake;
- per-word error flags.

It sits between the synchronised pad input and the SoC peripheral bus/FIFO.

Parameters:
CLK_FREQUENCY_HZ, 100000000, system clock frequency.
BAUD, 115200, line bit rate.
OVERSAMPLE, 16, sample ticks per bit; must be even and >=4.
DATA_BITS, 8, payload bits per frame, 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits checked, 1 or 2.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is the integrator's responsibility.
uart_rx  in  1  serial line, idle high, asynchronous to clk.
data  out  DATA_BITS  received payload, LSB = first bit on line.
valid  out  1  data/flags hold a word.
ready  in  1  consumer accepts the word when valid&&ready.
parity_err  out  1  parity mismatch for the held word.
frame_err  out  1  a stop bit sampled low for the held word.
overrun  out  1  sticky: a frame completed while valid&&!ready.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0): all outputs 0; state IDLE; synchroniser flops and sample registers set to 1.
- Input path: 2-flop synchroniser on uart_rx; all logic uses the synchronised value rx_s.
- Tick generator:
  - Divisor DIV = CLK_FREQUENCY_HZ/(BAUD*OVERSAMPLE), integer division.
  - DIV<1, odd OVERSAMPLE, or DATA_BITS/PARITY/STOP_BITS out of range -> elaboration $error.
  - Tick counter free-runs, except it is restarted on start-edge detection so sampling phase aligns to the edge.
- Bit sampling: each bit is decided by majority of rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit.
- States:
  - IDLE: rx_s 1->0 -> START.
  - START: at mid-bit, majority 1 -> false start, back to IDLE, no output; majority 0 -> DATA.
  - DATA: shift DATA_BITS bits, LSB first. After the last bit -> PARITY if PARITY!=0, else STOP.
  - PARITY: compute expected parity of payload: odd -> XOR of payload inverted; even -> XOR of payload. Compare with sampled bit.
  - STOP: sample STOP_BITS stop bits. Any low -> frame_err for this word. After mid-sample of the final stop bit, deliver the word, then:
    - if rx_s=1 -> IDLE immediately;
    - else -> BREAK.
  - BREAK: wait for rx_s=1, then IDLE. No further words delivered during BREAK.
- Delivery:
  - If !valid or (valid&&ready) in the delivery cycle: load data/parity_err/frame_err, valid=1 next cycle.
  - If valid&&!ready: the new word is dropped, the held word is unchanged, overrun<=1.
  - valid&&ready with no new word: valid<=0 next cycle; data/flags hold their last values.
- overrun clears only on reset.
- Latency: valid rises 1 clk after the final stop-bit mid-sample.
- Reset mid-frame: immediate return to IDLE, no partial word delivered.

Decomposition:
- Package uart_pkg:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN);
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - function for parity compute.
- Sub-module uart_baud_tick: parametrised divider with tick output and sync-restart input; reusable by the TX side.

Test Plan:
Common bench parameters: CLK_FREQUENCY_HZ=160, BAUD=10, OVERSAMPLE=4 (DIV=4, 16 clk/bit), DATA_BITS=8, ready held 1 unless stated.
1. 8N1 frame 0xA5 -> valid pulses one cycle, data=0xA5, parity_err=0, frame_err=0, overrun=0.
2. PARITY=2 (even), byte 0x03 with parity bit 0 -> data=0x03, parity_err=0. Same byte with parity bit 1 -> parity_err=1.
3. Line low for 6 clk then high (glitch shorter than half a bit) -> no valid, busy returns 0 within 1 bit time.
4. ready=0: send 0x11 then 0x22 -> data stays 0x11, valid=1, overrun=1. Then ready=1 -> valid drops, overrun stays 1.
5. Stop bit low (byte 0x00, line held low 30 bit times) -> word delivered with frame_err=1. busy stays high until the line returns high; no second word.
6. Assert rst (low) mid-DATA of 0x5A -> valid=0, busy=0 immediately. After release, a clean 0x3C frame -> data=0x3C.
